// File: rtl/jtcps1_dma_if.sv
// Shared-VRAM bus seen by the DMA: CPU bus-sharing handshake plus the
// VRAM read port. The DMA is the master; CPU arbitration and the VRAM
// controller together form the slave side.
interface jtcps1_dma_if #(
   parameter int AW = 17
);
   logic          busreq;
   logic          busack;
   logic [AW-1:0] vram_addr;
   logic          vram_cs;
   logic [15:0]   vram_data;
   logic          vram_ok;

   modport master (
      output busreq, vram_addr, vram_cs,
      input  busack, vram_data, vram_ok
   );

   modport slave (
      input  busreq, vram_addr, vram_cs,
      output busack, vram_data, vram_ok
   );
endinterface

// File: rtl/jtcps1_dma.sv
// jtcps1_dma: takes the main-CPU bus and copies the object table and the
// palette out of shared VRAM into the video chip's internal buffers.
// An object copy is triggered by the falling edge of LVBL; a palette copy
// by a pal_go pulse. Requests are latched in pending flags so none is lost,
// and a copy that finishes with the other kind pending chains straight into
// it without giving the bus back.
module jtcps1_dma #(
   parameter int AW      = 17,
   parameter int OBJ_LEN = 1024,
   parameter int PAL_LEN = 3072,
   parameter int CW      = 12
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          LVBL,
   input  logic          pal_go,
   input  logic [AW-1:0] obj_base,
   input  logic [AW-1:0] pal_base,
   jtcps1_dma_if.master  bus,
   output logic          wr_en,
   output logic          wr_sel,
   output logic [CW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   output logic          busy
);

   typedef enum logic [2:0] {
      IDLE,     // no copy pending, bus released
      REQ,      // busreq high, waiting for the grant
      SETTLE,   // new address presented; any vram_ok here belongs to the old one
      READ,     // holding the address until vram_ok
      WRITE,    // one-cycle write into the internal buffer
      RELEASE   // busreq low, waiting for the CPU to take the bus back
   } state_t;

   localparam logic [CW-1:0] OBJ_LAST = CW'(OBJ_LEN - 1);
   localparam logic [CW-1:0] PAL_LAST = CW'(PAL_LEN - 1);

   state_t        state, state_nxt;
   logic          lvbl_l;
   logic          obj_trig;
   logic          obj_pend, pal_pend;
   logic          obj_clr, pal_clr;
   logic [AW-1:0] base, base_nxt;
   logic [AW-1:0] addr_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] wr_addr_nxt;
   logic [15:0]   wr_data_nxt;
   logic          sel_nxt;
   logic          last;
   logic          other_pend;

   // wr_sel doubles as "which copy is running": 0 object, 1 palette.
   assign obj_trig   = lvbl_l & ~LVBL;
   assign last       = (cnt == (wr_sel ? PAL_LAST : OBJ_LAST));
   assign other_pend = wr_sel ? obj_pend : pal_pend;

   // Bus-facing strobes decode straight from the state register; vram_cs is
   // also gated by busack so it can never be seen while the bus is not ours.
   assign bus.busreq  = (state == REQ) || (state == SETTLE) ||
                        (state == READ) || (state == WRITE);
   assign bus.vram_cs = ((state == SETTLE) || (state == READ)) && bus.busack;
   assign wr_en       = (state == WRITE);
   assign busy        = (state != IDLE);

   // Trigger capture: a trigger always wins over the clear of the same flag,
   // so a request that lands while its own copy starts is kept for a rerun.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lvbl_l   <= 1'b0;
         obj_pend <= 1'b0;
         pal_pend <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // process sees the pre-edge values during the same clock edge.
         lvbl_l   <= LVBL;
         obj_pend <= (obj_pend & ~obj_clr) | obj_trig;
         pal_pend <= (pal_pend & ~pal_clr) | pal_go;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Datapath registers: copy base, word counter, VRAM address and the
   // buffer write port. All cleared by reset so an aborted copy leaves no trace.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         base          <= '0;
         cnt           <= '0;
         wr_sel        <= 1'b0;
         bus.vram_addr <= '0;
         wr_addr       <= '0;
         wr_data       <= '0;
      end else begin
         base          <= base_nxt;
         cnt           <= cnt_nxt;
         wr_sel        <= sel_nxt;
         bus.vram_addr <= addr_nxt;
         wr_addr       <= wr_addr_nxt;
         wr_data       <= wr_data_nxt;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path through
      // the case statement can leave it unassigned and infer a latch.
      state_nxt   = state;
      base_nxt    = base;
      cnt_nxt     = cnt;
      sel_nxt     = wr_sel;
      addr_nxt    = bus.vram_addr;
      wr_addr_nxt = wr_addr;
      wr_data_nxt = wr_data;
      obj_clr     = 1'b0;
      pal_clr     = 1'b0;

      case (state)
         IDLE: begin
            if (obj_pend || pal_pend) begin
               // Object copy has priority when both are pending.
               state_nxt = REQ;
               sel_nxt   = ~obj_pend;
               base_nxt  = obj_pend ? obj_base : pal_base;
               cnt_nxt   = '0;
               obj_clr   = obj_pend;
               pal_clr   = ~obj_pend;
            end
         end

         REQ: begin
            // Also the re-entry point after a lost grant: the counter is kept,
            // so the same word is re-addressed.
            if (bus.busack) begin
               state_nxt = SETTLE;
               addr_nxt  = base + AW'(cnt);
            end
         end

         SETTLE: begin
            state_nxt = bus.busack ? READ : REQ;
         end

         READ: begin
            if (!bus.busack) begin
               state_nxt = REQ;
            end else if (bus.vram_ok) begin
               state_nxt   = WRITE;
               wr_data_nxt = bus.vram_data;
               wr_addr_nxt = cnt;
            end
         end

         WRITE: begin
            if (!last) begin
               state_nxt = SETTLE;
               cnt_nxt   = CW'(cnt + 1'b1);
               addr_nxt  = base + AW'(CW'(cnt + 1'b1));
            end else if (other_pend) begin
               // Chain into the other table while we still own the bus.
               state_nxt = SETTLE;
               sel_nxt   = ~wr_sel;
               base_nxt  = wr_sel ? obj_base : pal_base;
               addr_nxt  = wr_sel ? obj_base : pal_base;
               cnt_nxt   = '0;
               obj_clr   = wr_sel;
               pal_clr   = ~wr_sel;
            end else begin
               state_nxt = RELEASE;
            end
         end

         RELEASE: begin
            if (!bus.busack) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_jtcps1_dma.sv
// Self-checking bench for jtcps1_dma. A bus-arbitration model and a VRAM
// model respond on the falling clock edge; every expected buffer write is
// queued when a copy is triggered and compared as the DUT writes it.
module tb_jtcps1_dma;

   localparam int AW = 17;
   localparam int CW = 12;

   typedef struct packed {
      logic          sel;
      logic [CW-1:0] addr;
      logic [15:0]   data;
   } exp_t;

   logic          clk = 1'b1;
   logic          rstn = 1'b0;
   logic          LVBL = 1'b1;
   logic          pal_go = 1'b0;
   logic [AW-1:0] obj_base = '0;
   logic [AW-1:0] pal_base = '0;
   logic          wr_en, wr_sel, busy;
   logic [CW-1:0] wr_addr;
   logic [15:0]   wr_data;

   jtcps1_dma_if #(.AW(AW)) bus ();

   jtcps1_dma #(.AW(AW), .OBJ_LEN(1024), .PAL_LEN(3072), .CW(CW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .LVBL     (LVBL),
      .pal_go   (pal_go),
      .obj_base (obj_base),
      .pal_base (pal_base),
      .bus      (bus.master),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Model controls, written only by the main initial block.
   int grant_dly  = 4;
   int ok_delay   = 3;
   bit stale_mode = 1'b0;
   bit force_drop = 1'b0;

   // Per-run observations, written only by run_copy.
   int n_rel, min_gap, max_gap, cs_viol, drop_cycles;

   function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
      return a[15:0] ^ {a[16], a[16:2]} ^ 16'h5A3C;
   endfunction

   // Arbitration model: grant after grant_dly cycles of request; drop on
   // force_drop or once the request goes away.
   int gcnt = 0;
   always @(negedge clk) begin
      if (force_drop || bus.busreq !== 1'b1) begin
         bus.busack <= 1'b0;
         gcnt       <= 0;
      end else if (gcnt >= grant_dly) begin
         bus.busack <= 1'b1;
      end else begin
         gcnt <= gcnt + 1;
      end
   end

   // VRAM model. Normal: ok after ok_delay cycles of cs with correct data.
   // Stale: ok stuck high and data lagging one cycle behind the address.
   int            ok_cnt = 0;
   logic [AW-1:0] lag_addr = '0;
   always @(negedge clk) begin
      lag_addr <= bus.vram_addr;
      ok_cnt   <= (bus.vram_cs === 1'b1) ? ok_cnt + 1 : 0;
      if (stale_mode) begin
         bus.vram_ok   <= 1'b1;
         bus.vram_data <= mem_word(lag_addr);
      end else if (bus.vram_cs === 1'b1 && ok_cnt + 1 >= ok_delay) begin
         bus.vram_ok   <= 1'b1;
         bus.vram_data <= mem_word(bus.vram_addr);
      end else begin
         bus.vram_ok   <= 1'b0;
         bus.vram_data <= 16'hDEAD;
      end
   end

   task automatic push_copy(input bit sel, input logic [AW-1:0] base, input int len);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.sel  = sel;
         e.addr = CW'(i);
         e.data = mem_word(AW'(base + i));
         exp_q.push_back(e);
      end
   endtask

   task automatic fire(input bit obj, input bit pal);
      @(negedge clk); #1;
      if (obj) LVBL = 1'b0;
      if (pal) pal_go = 1'b1;
      @(negedge clk); #1;
      LVBL   = 1'b1;
      pal_go = 1'b0;
   endtask

   // Steps the bench until the queue is drained and the DUT is idle (or
   // stop_at writes seen), comparing each buffer write against the queue.
   task automatic run_copy(input string name, input int budget, input int pal_at,
                           input int drop_at, input int stop_at);
      int   n_wr, last_cyc, drop_left;
      bit   prev_req, done;
      exp_t e;
      n_rel = 0; min_gap = 1 << 30; max_gap = 0; cs_viol = 0; drop_cycles = 0;
      n_wr = 0; last_cyc = -1; drop_left = 0; done = 1'b0;
      prev_req = bus.busreq;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         @(negedge clk); #1;
         pal_go = 1'b0;
         if (bus.vram_cs === 1'b1 && bus.busack !== 1'b1) cs_viol++;
         if (prev_req && bus.busreq === 1'b0) n_rel++;
         prev_req = bus.busreq;
         if (force_drop && bus.busack === 1'b0 && bus.busreq === 1'b1) drop_cycles++;
         if (drop_left > 0) begin
            drop_left--;
            if (drop_left == 0) force_drop = 1'b0;
         end
         if (wr_en === 1'b1) begin
            if (last_cyc >= 0) begin
               if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
               if (cyc - last_cyc > max_gap) max_gap = cyc - last_cyc;
            end
            last_cyc = cyc;
            n_wr++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_write: got sel=%0d addr=%0d data=%h, expected no write",
                        name, wr_sel, wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               if ({wr_sel, wr_addr, wr_data} !== e) begin
                  errors++;
                  $display("FAIL %s write[%0d]: got sel=%0d addr=%0d data=%h, expected sel=%0d addr=%0d data=%h",
                           name, n_wr - 1, wr_sel, wr_addr, wr_data, e.sel, e.addr, e.data);
               end
            end
            if (n_wr == pal_at) pal_go = 1'b1;
            if (drop_at >= 0 && int'(wr_addr) == drop_at && drop_cycles == 0 && drop_left == 0) begin
               force_drop = 1'b1;
               drop_left  = 6;
            end
            if (n_wr == stop_at) done = 1'b1;
         end
         if (stop_at < 0 && exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got %0d writes, %0d still expected, busy=%b",
                  name, n_wr, exp_q.size(), busy);
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({bus.busreq, busy, bus.vram_cs, wr_en} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got busreq/busy/cs/wr_en=%b, expected 0000",
                  {bus.busreq, busy, bus.vram_cs, wr_en});
      end
      checks++;
      if (bus.vram_addr !== '0) begin
         errors++; $display("FAIL reset_vram_addr: got %h, expected 0", bus.vram_addr);
      end
      checks++;
      if (wr_addr !== '0) begin
         errors++; $display("FAIL reset_wr_addr: got %h, expected 0", wr_addr);
      end
      checks++;
      if (wr_data !== '0) begin
         errors++; $display("FAIL reset_wr_data: got %h, expected 0", wr_data);
      end
      rstn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_obj_copy;
      grant_dly = 4; ok_delay = 3; stale_mode = 1'b0;
      obj_base  = 17'h01000;
      push_copy(1'b0, obj_base, 1024);
      fire(1'b1, 1'b0);
      run_copy("obj", 8000, -1, -1, -1);
      checks++;
      if (n_rel !== 1) begin
         errors++; $display("FAIL obj_release: got %0d releases, expected 1", n_rel);
      end
      checks++;
      if (cs_viol !== 0) begin
         errors++; $display("FAIL obj_cs_no_ack: got %0d cycles, expected 0", cs_viol);
      end
      checks++;
      if ({bus.busreq, busy} !== 2'b00) begin
         errors++; $display("FAIL obj_idle: got busreq/busy=%b, expected 00", {bus.busreq, busy});
      end
   endtask

   task automatic test_back_to_back;
      grant_dly = 4; ok_delay = 1;
      obj_base  = 17'h01000;
      pal_base  = 17'h1FC00;   // palette wraps the 17-bit address space
      push_copy(1'b0, obj_base, 1024);
      push_copy(1'b1, pal_base, 3072);
      fire(1'b1, 1'b0);
      run_copy("b2b", 20000, 500, -1, -1);
      checks++;
      if (n_rel !== 1) begin
         errors++; $display("FAIL b2b_release: got %0d releases, expected 1", n_rel);
      end
      checks++;
      if (cs_viol !== 0) begin
         errors++; $display("FAIL b2b_cs_no_ack: got %0d cycles, expected 0", cs_viol);
      end
   endtask

   task automatic test_simultaneous;
      grant_dly = 2; ok_delay = 1;
      obj_base  = 17'h02345;
      pal_base  = 17'h08000;
      push_copy(1'b0, obj_base, 1024);
      push_copy(1'b1, pal_base, 3072);
      fire(1'b1, 1'b1);
      run_copy("simul", 20000, -1, -1, -1);
      checks++;
      if (n_rel !== 1) begin
         errors++; $display("FAIL simul_release: got %0d releases, expected 1", n_rel);
      end
   endtask

   task automatic test_retrigger;
      grant_dly = 3; ok_delay = 1;
      pal_base  = 17'h10000;
      push_copy(1'b1, pal_base, 3072);
      push_copy(1'b1, pal_base, 3072);
      fire(1'b0, 1'b1);
      run_copy("retrig", 30000, 100, -1, -1);
      checks++;
      if (n_rel !== 2) begin
         errors++; $display("FAIL retrig_release: got %0d releases, expected 2", n_rel);
      end
   endtask

   task automatic test_stale_ok;
      grant_dly = 4; stale_mode = 1'b1;
      obj_base  = 17'h0ABCD;
      push_copy(1'b0, obj_base, 1024);
      fire(1'b1, 1'b0);
      run_copy("stale", 6000, -1, -1, -1);
      stale_mode = 1'b0;
      checks++;
      if (min_gap !== 3 || max_gap !== 3) begin
         errors++;
         $display("FAIL stale_word_period: got min=%0d max=%0d clk, expected 3 and 3", min_gap, max_gap);
      end
   endtask

   task automatic test_busack_loss;
      grant_dly = 0; ok_delay = 2;
      obj_base  = 17'h1FF00;
      push_copy(1'b0, obj_base, 1024);
      fire(1'b1, 1'b0);
      run_copy("ackloss", 6000, -1, 10, -1);
      checks++;
      if (drop_cycles !== 6) begin
         errors++; $display("FAIL ackloss_drop: got %0d dropped cycles, expected 6", drop_cycles);
      end
      checks++;
      if (cs_viol !== 0) begin
         errors++; $display("FAIL ackloss_cs: got %0d cs-without-ack cycles, expected 0", cs_viol);
      end
      checks++;
      if (n_rel !== 1) begin
         errors++; $display("FAIL ackloss_release: got %0d releases, expected 1", n_rel);
      end
   endtask

   task automatic test_reset_mid;
      int act;
      grant_dly = 4; ok_delay = 3;
      obj_base  = 17'h01000;
      push_copy(1'b0, obj_base, 1024);
      fire(1'b1, 1'b0);
      run_copy("rstmid", 4000, -1, -1, 20);
      rstn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus.busreq, busy, wr_en} !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_ctrl: got busreq/busy/wr_en=%b, expected 000", {bus.busreq, busy, wr_en});
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      act = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (wr_en !== 1'b0 || busy !== 1'b0 || bus.busreq !== 1'b0) act++;
      end
      checks++;
      if (act !== 0) begin
         errors++; $display("FAIL rstmid_no_resume: got %0d active cycles, expected 0", act);
      end
   endtask

   initial begin
      test_reset();
      test_obj_copy();
      test_back_to_back();
      test_simultaneous();
      test_retrigger();
      test_stale_ok();
      test_busack_loss();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
